// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, FSM state encoding and queued-command layout for the APB request sequencer
package apb_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: power-of-two command queue without bypass
// Ports: clk, rst_n (sync, active-low); push/din write the tail; pop advances the head,
// dout shows the head; full/empty/count report occupancy.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  cmd_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/apb_req_sequencer.sv
// apb_req_sequencer: queues upstream commands and launches them one at a time on an APB master
// Ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata upstream
// command handshake; start/addr/data/write launch a transfer; xfer_done/rdata report completion;
// rsp_valid/rsp_addr/rsp_data return read results; busy = queued or in flight; err = sticky timeout.
module apb_req_sequencer
  import apb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              write,
  input  logic              xfer_done,
  input  logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  cmd_t head, cmd_in;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, push, pop, done, tmo;
  logic [WW-1:0] wcnt;
  assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state == WAIT) || !empty;
  apb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // A completion during the launch cycle belongs to no transfer we issued, so it is ignored.
  always_comb begin
    done    = (state == WAIT) && xfer_done && !start;
    tmo     = (state == WAIT) && !done && (wcnt == WW'(TIMEOUT - 1));
    pop     = (state == IDLE) && !empty;
    state_n = pop ? WAIT : (done || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start     <= 1'b0;
      addr      <= '0;
      data      <= '0;
      write     <= 1'b0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      start     <= pop;
      rsp_valid <= done && !write;
      if (pop) begin
        addr  <= head.addr;
        data  <= head.wdata;
        write <= head.write;
      end
      wcnt <= pop ? '0 : (state == WAIT && !done) ? wcnt + 1'b1 : wcnt;
      if (done && !write) begin
        rsp_addr <= addr;
        rsp_data <= rdata;
      end
      if (tmo) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_req_sequencer.sv
// tb_apb_req_sequencer: directed self-checking bench for apb_req_sequencer
module tb_apb_req_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_write, xfer_done;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata, rdata;
  logic        cmd_ready, start, write, rsp_valid, busy, err;
  logic [3:0]  addr, rsp_addr;
  logic [15:0] data, rsp_data;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem [16];
  logic [15:0] wv [4];
  logic        rv;
  logic [3:0]  ra;
  logic [15:0] rd;

  always #5 clk = ~clk;

  apb_req_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .start     (start),
    .addr      (addr),
    .data      (data),
    .write     (write),
    .xfer_done (xfer_done),
    .rdata     (rdata),
    .rsp_valid (rsp_valid),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(negedge clk);
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Slave model: waits for a launch, completes it lat cycles later, returns the response seen.
  task automatic serve(input int lat, output logic ov, output logic [3:0] oa, output logic [15:0] od);
    int n = 0;
    logic w;
    logic [3:0] a;
    logic [15:0] d;
    while (!start && n < 20) begin tick(); n++; end
    chk("start_seen", start, 1);
    a = addr; d = data; w = write;
    repeat (lat) tick();
    xfer_done = 1'b1;
    rdata = w ? 16'h0 : mem[a];
    if (w) mem[a] = d;
    tick();
    xfer_done = 1'b0;
    ov = rsp_valid; oa = rsp_addr; od = rsp_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    xfer_done = 1'b0; rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    wv[0] = 16'hFACE; wv[1] = 16'hCAFE; wv[2] = 16'hFFFF; wv[3] = 16'hBEEF;
    tick(); tick();
    chk("rst_start", start, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_write", write, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();
    // single write FACE -> 15
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hF; cmd_wdata = 16'hFACE;
    tick();
    cmd_valid = 1'b0;
    chk("no_bypass_start", start, 0);
    chk("busy_queued", busy, 1);
    tick();
    chk("w_start", start, 1);
    chk("w_addr", addr, 15);
    chk("w_data", data, 16'hFACE);
    chk("w_write", write, 1);
    tick();
    chk("w_start_pulse", start, 0);
    chk("w_addr_hold", addr, 15);
    chk("w_data_hold", data, 16'hFACE);
    chk("w_write_hold", write, 1);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("w_no_rsp", rsp_valid, 0);
    chk("w_idle_busy", busy, 0);
    chk("w_no_restart", start, 0);
    // writes then reads through the slave model
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'(15 - i), wv[i]);
      serve(1 + i % 2, rv, ra, rd);
      chk("wr_no_rsp", rv, 0);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 4'(15 - i), 16'h0);
      serve(2, rv, ra, rd);
      chk("rd_rsp_valid", rv, 1);
      chk("rd_rsp_addr", ra, 15 - i);
      chk("rd_rsp_data", rd, wv[i]);
    end
    tick();
    chk("rsp_pulse", rsp_valid, 0);
    // completions in IDLE and during the launch cycle are ignored
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("idle_done_rsp", rsp_valid, 0);
    chk("idle_done_busy", busy, 0);
    send(1'b0, 4'd5, 16'h0);
    tick();
    chk("ign_start", start, 1);
    xfer_done = 1'b1; rdata = 16'h1234;
    tick();
    xfer_done = 1'b0;
    chk("ign_rsp", rsp_valid, 0);
    chk("ign_busy", busy, 1);
    xfer_done = 1'b1; rdata = 16'h5555;
    tick();
    xfer_done = 1'b0;
    chk("ign_then_rsp", rsp_valid, 1);
    chk("ign_then_addr", rsp_addr, 5);
    chk("ign_then_data", rsp_data, 16'h5555);
    // back-to-back pushes with completion withheld
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'(i);
      chk("bb_ready", cmd_ready, 1);
      tick();
    end
    cmd_addr = 4'd5;
    chk("full_ready_low", cmd_ready, 0);
    tick(); tick();
    chk("stall_holds", cmd_ready, 0);
    rdata = 16'hA000; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("bb0_rsp", rsp_valid, 1);
    chk("bb0_addr", rsp_addr, 0);
    chk("bb0_data", rsp_data, 16'hA000);
    chk("bb_still_full", cmd_ready, 0);
    tick();
    chk("bb1_start", start, 1);
    chk("bb1_addr", addr, 1);
    chk("slot_freed", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    rdata = 16'hA001; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("bb1_addr_rsp", rsp_addr, 1);
    for (int i = 2; i < 6; i++) begin
      serve(1, rv, ra, rd);
      chk("bb_rsp_valid", rv, 1);
      chk("bb_rsp_addr", ra, i);
      chk("bb_rsp_data", rd, 16'hA000 + i);
    end
    chk("bb_drained", busy, 0);
    // timeout
    chk("pre_tmo_err", err, 0);
    send(1'b0, 4'd3, 16'h0);
    tick();
    chk("tmo_start", start, 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("tmo_no_rsp", rsp_valid, 0);
    end
    chk("tmo_err_early", err, 0);
    chk("tmo_busy", busy, 1);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_rsp", rsp_valid, 0);
    send(1'b1, 4'd9, 16'h1111);
    serve(1, rv, ra, rd);
    chk("post_tmo_no_rsp", rv, 0);
    chk("err_sticky", err, 1);
    // reset during WAIT with two commands queued
    send(1'b0, 4'd1, 16'h0);
    send(1'b0, 4'd2, 16'h0);
    send(1'b0, 4'd3, 16'h0);
    chk("mid_busy", busy, 1);
    chk("mid_start", start, 0);
    rst_n = 1'b0;
    tick();
    chk("mr_start", start, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_rsp", rsp_valid, 0);
    chk("mr_err", err, 0);
    chk("mr_addr", addr, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_start", start, 0);
      chk("post_rst_rsp", rsp_valid, 0);
    end
    chk("post_rst_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
